multicycle_controller: RTL
==========================

# multicycle_controller

Moore-style control FSM for the multicycle computer. Sits directly upstream of `multicycle_computer_datapath_verilog`. Takes the latched instruction (`INSTRUCTION_OUT`) and `FLAGS` from the datapath, and drives every datapath control input each cycle. This replaces hand-sequenced control. Supports conditional data-processing, LDR/STR with immediate offset, B and BL.

## Interface
- No parameters.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `INSTRUCTION_OUT` in 32: instruction register contents from the datapath.
- `FLAGS` in 4: {N,Z,C,V} = FLAGS[3:0] from the datapath flag register.
- `A3Src`, `AdrSrc`, `FlagUpdate`, `IRWrite`, `MemWrite`, `PCWrite`, `RegWrite`, `WD3Src` out 1 each: datapath controls.
- `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `RegSrc` out 2 each: datapath mux selects.
- `ALUop`, `ShiftType` out 3 each: ALU operation and shifter mode.
- `state_out` out 4: current state encoding, for debug and bench.

## Operation

**Instruction fields**
- `cond`=[31:28], `op`=[27:26], `I`=[25], `cmd`=[24:21], `S/L`=[20], `Rd`=[15:12].
- For branches, the link bit is [24].

**States**
FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.

**Transitions**
- FETCH → DECODE, always.
- DECODE:
  - cond false → FETCH.
  - op=01 → MEMADR.
  - op=00 with I=0 → EXECR.
  - op=00 with I=1 → EXECI.
  - op=10 → BRANCH.
  - op=11 (undefined) → FETCH.
- MEMADR: L=1 → MEMREAD; L=0 → MEMWRITE.
- MEMREAD → MEMWB → FETCH.
- MEMWRITE → FETCH.
- EXECR/EXECI → ALUWB → FETCH.
- BRANCH → FETCH.

**Condition check** (combinational in DECODE)
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
- HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
- AL 1110 is true. 1111 is false.

**Outputs per state** (unlisted signals are 0; `ShiftType`=111, `ALUop`=000, `RegSrc`=10 unless stated)
- FETCH: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=11, ResultSrc=10.
- DECODE: ALUSrcB=11, ResultSrc=10. No write enables.
- MEMADR: ALUSrcA=01, ALUSrcB=01. `ALUop`=000 if U=[23]=1, else 001.
- MEMREAD: AdrSrc=1, plus the MEMADR selects.
- MEMWB: AdrSrc=1, ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=01, ALUSrcB=00, RegSrc=00, ShiftType={0,[6:5]}.
- EXECI: ALUSrcA=01, ALUSrcB=01, RegSrc=00.
- ALUWB:
  - ResultSrc=00, RegSrc=00, ALUSrcA/ALUSrcB held from EXEC.
  - RegWrite=1 unless cmd=1010 (CMP).
  - FlagUpdate=S.
- BRANCH:
  - ALUSrcA=01, ALUSrcB=01, RegSrc=01, ResultSrc=10, PCWrite=1.
  - Link=1 additionally asserts RegWrite=1, A3Src=1 (R14), WD3Src=1 (old PC).

**ALUop from cmd** (EXECR, EXECI, ALUWB)
- AND 0000→010, EOR 0001→100, SUB 0010→001, ADD 0100→000.
- CMP 1010→001, ORR 1100→011, MOV 1101→101.
- Any other cmd → 000 with RegWrite suppressed.

## Timing
- `state_out` reset value is FETCH.
- Cycle following reset:
  - While `reset` is high at the edge, the next state is FETCH.
  - Outputs during the reset-high cycle are all 0, `ShiftType`=111, `RegSrc`=10.
- Reset asserted mid-instruction aborts it at the next edge. No partial writes occur after that edge.
- Outputs are a function of state and the latched `INSTRUCTION_OUT`, so they are glitch-stable within a cycle. `FLAGS` affects only the DECODE transition.
- Latency in cycles (count includes FETCH):
  - LDR 5.
  - STR 4.
  - DP 4.
  - B/BL 3.
  - Condition-failed or undefined instruction 2.
- `INSTRUCTION_OUT` changes only after FETCH (IRWrite). DECODE decodes the newly latched word.
- The CMP flag update in ALUWB is visible to the next instruction's DECODE.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum (4-bit);
  - op codes (DP=00, MEM=01, BR=10);
  - cmd encodings;
  - ALUop values;
  - ShiftType none=111;
  - ALUSrcA/ALUSrcB/ResultSrc select constants.
- One sub-module `cond_check` takes (`cond`, `FLAGS`) and outputs `cond_ok`. It is purely combinational.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset held for 1 edge, then `INSTRUCTION_OUT`=0xE5900040 (LDR R0,[R0,#64]):
  - state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH;
  - RegWrite=1 only in MEMWB with ResultSrc=01.
- 0xE5810041 (STR R0,[R1,#65]): MemWrite=1 and AdrSrc=1 in exactly one cycle (MEMWRITE); RegWrite stays 0 throughout.
- 0xE0802001 (ADD R2,R0,R1): EXECR has ALUop=000, ALUSrcB=00; ALUWB has RegWrite=1, FlagUpdate=0.
- 0xE1500001 (CMP): ALUWB has ALUop=001, FlagUpdate=1, RegWrite=0.
- 0x0A000002 (BEQ):
  - with FLAGS=0100: BRANCH has PCWrite=1;
  - with FLAGS=0000: DECODE→FETCH with no write enables;
  - 0xEB000004 (BL): BRANCH has A3Src=1, WD3Src=1, RegWrite=1.
- Reset asserted during MEMREAD: next cycle state_out=FETCH, RegWrite and MemWrite=0; 0xFE000000 (op=11) takes a 2-cycle path.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// field codes, and the datapath select/operation values it drives.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [2:0] SHIFT_NONE = 3'b111;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REG  = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_DEF = 2'b10;

    function automatic logic [2:0] alu_for_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_AND: return ALU_AND;
            CMD_EOR: return ALU_EOR;
            CMD_SUB: return ALU_SUB;
            CMD_ADD: return ALU_ADD;
            CMD_CMP: return ALU_SUB;
            CMD_ORR: return ALU_ORR;
            CMD_MOV: return ALU_MOV;
            default: return ALU_ADD;
        endcase
    endfunction

    // CMP only sets flags; unsupported commands must never write a register.
    function automatic logic cmd_writes_rd(input logic [3:0] cmd);
        case (cmd)
            CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD,
            CMD_ORR, CMD_MOV: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Combinational evaluation of an instruction's condition field against the
// {N,Z,C,V} flag register.
module cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] FLAGS,
    output logic       cond_ok
);

    logic n, z, c, v;

    assign n = FLAGS[3];
    assign z = FLAGS[2];
    assign c = FLAGS[1];
    assign v = FLAGS[0];

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = z;
            4'b0001: cond_ok = !z;
            4'b0010: cond_ok = c;
            4'b0011: cond_ok = !c;
            4'b0100: cond_ok = n;
            4'b0101: cond_ok = !n;
            4'b0110: cond_ok = v;
            4'b0111: cond_ok = !v;
            4'b1000: cond_ok = c && !z;
            4'b1001: cond_ok = !c || z;
            4'b1010: cond_ok = (n == v);
            4'b1011: cond_ok = (n != v);
            4'b1100: cond_ok = !z && (n == v);
            4'b1101: cond_ok = z || (n != v);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle computer: sequences fetch, decode and
// execute of data-processing, LDR/STR and B/BL instructions.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  state_out
);

    state_e     state, next_state;
    logic [3:0] cond, cmd;
    logic [1:0] op, sh;
    logic       imm, sbit, ubit, link, cond_ok;
    logic       unused_fields;

    assign cond = INSTRUCTION_OUT[31:28];
    assign op   = INSTRUCTION_OUT[27:26];
    assign imm  = INSTRUCTION_OUT[25];
    assign cmd  = INSTRUCTION_OUT[24:21];
    assign link = INSTRUCTION_OUT[24];
    assign ubit = INSTRUCTION_OUT[23];
    assign sbit = INSTRUCTION_OUT[20];
    assign sh   = INSTRUCTION_OUT[6:5];

    assign unused_fields = ^{INSTRUCTION_OUT[22], INSTRUCTION_OUT[19:7], INSTRUCTION_OUT[4:0]};

    cond_check u_cond_check (
        .cond    (cond),
        .FLAGS   (FLAGS),
        .cond_ok (cond_ok)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    assign state_out = state;

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                if (cond_ok) begin
                    case (op)
                        OP_MEM:  next_state = MEMADR;
                        OP_DP:   next_state = imm ? EXECI : EXECR;
                        OP_BR:   next_state = BRANCH;
                        default: next_state = FETCH;
                    endcase
                end
            end
            MEMADR:  next_state = sbit ? MEMREAD : MEMWRITE;
            MEMREAD: next_state = MEMWB;
            EXECR:   next_state = ALUWB;
            EXECI:   next_state = ALUWB;
            default: next_state = FETCH;
        endcase
    end

    // Outputs are gated by reset so an aborted instruction cannot write anything.
    always_comb begin
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        RegSrc     = REGSRC_DEF;
        ALUop      = ALU_ADD;
        ShiftType  = SHIFT_NONE;
        if (!reset) begin
            case (state)
                FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                end
                DECODE: begin
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                end
                MEMADR, MEMREAD: begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_IMM;
                    ALUop   = ubit ? ALU_ADD : ALU_SUB;
                    AdrSrc  = (state == MEMREAD);
                end
                MEMWB: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = RES_MEM;
                    RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                EXECR: begin
                    ALUSrcA   = SRCA_REG;
                    ALUSrcB   = SRCB_REG;
                    RegSrc    = REGSRC_DP;
                    ALUop     = alu_for_cmd(cmd);
                    ShiftType = {1'b0, sh};
                end
                EXECI: begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_IMM;
                    RegSrc  = REGSRC_DP;
                    ALUop   = alu_for_cmd(cmd);
                end
                ALUWB: begin
                    ALUSrcA    = SRCA_REG;
                    ALUSrcB    = imm ? SRCB_IMM : SRCB_REG;
                    ResultSrc  = RES_ALUOUT;
                    RegSrc     = REGSRC_DP;
                    ALUop      = alu_for_cmd(cmd);
                    RegWrite   = cmd_writes_rd(cmd);
                    FlagUpdate = sbit;
                end
                BRANCH: begin
                    ALUSrcA   = SRCA_REG;
                    ALUSrcB   = SRCB_IMM;
                    RegSrc    = REGSRC_BR;
                    ResultSrc = RES_ALU;
                    PCWrite   = 1'b1;
                    RegWrite  = link;
                    A3Src     = link;
                    WD3Src    = link;
                end
                default: ;
            endcase
        end
    end

endmodule
